// File: rtl/gb_result_reader.sv
// Global-buffer result reader: streams n_lines GB lines to the host over valid/ready,
// issuing credit-limited GB reads and absorbing host backpressure in a small skid FIFO.
module gb_result_reader #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int length     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        n_lines,
  output logic                         gb_ren,
  output logic [ADDR_WIDTH-1:0]        gb_raddr,
  input  logic [DATA_WIDTH*length-1:0] gb_rdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH*length-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = DATA_WIDTH * length;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] issued;
  logic [ADDR_WIDTH-1:0] sent;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  inflight;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [LW-1:0]         mem [FIFO_DEPTH];
  logic                  room;
  logic                  push;
  logic                  pop;
  logic                  last_beat;

  always_comb begin
    // Credit: a read is only issued if its line is guaranteed a FIFO slot on capture.
    room      = (32'(count) + 32'(inflight)) < FIFO_DEPTH;
    gb_ren    = (state == READ) && (issued != n_q) && room;
    gb_raddr  = gb_ren ? base_q + issued : raddr_q;
    push      = inflight;
    m_valid   = (count != '0);
    pop       = m_valid && m_ready;
    m_data    = m_valid ? mem[rd_ptr] : '0;
    m_last    = m_valid && (sent == n_q - 1'b1);
    last_beat = pop && m_last;
    busy      = (state == READ) || (state == DRAIN);
    done      = (state == FIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      base_q   <= '0;
      n_q      <= '0;
      issued   <= '0;
      sent     <= '0;
      raddr_q  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= gb_ren;
      if (gb_ren) begin
        issued  <= issued + 1'b1;
        raddr_q <= gb_raddr;
      end
      if (pop) begin
        sent   <= sent + 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          n_q    <= n_lines;
          issued <= '0;
          sent   <= '0;
          state  <= READ;
        end
        // An empty transfer passes through READ for one cycle so done lands two cycles after start.
        READ:    if (issued == n_q) state <= (n_q == '0) ? FIN : DRAIN;
        DRAIN:   if (last_beat) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gb_rdata;
  end

endmodule

// File: tb/tb_gb_result_reader.sv
// Bench for gb_result_reader: GB memory model, random host backpressure, and a
// transfer-level reference model checked against the DUT every cycle.
module tb_gb_result_reader;

  localparam int AW = 17;
  localparam int LW = 128;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] n_lines;
  logic          gb_ren;
  logic [AW-1:0] gb_raddr;
  logic [LW-1:0] gb_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [LW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  gb_result_reader #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .length(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .n_lines(n_lines),
    .gb_ren(gb_ren), .gb_raddr(gb_raddr), .gb_rdata(gb_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {15'h0, a};
    return {~w, w * 32'h9E3779B1, w ^ 32'h5A5A5A5A, w + 32'h1234};
  endfunction

  // GB memory: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    if (gb_ren) gb_rdata <= line_of(gb_raddr);
    else        gb_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transfer described by its start cycle, read count and beat count.
  bit            xfer = 0;
  int            s_cyc, mn, nrd, npop, done_cyc;
  logic [AW-1:0] mbase;
  logic [AW-1:0] last_addr;
  int            avail [256];
  logic [AW-1:0] addr_log [$];
  int            done_cnt = 0;
  int            last_cnt = 0;
  int            last_done_cyc = -1;

  always @(negedge clk) begin
    bit            e_busy, e_done, e_ren, e_valid, e_last;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_data;
    if (!rstn) begin
      check("rst_ren", LW'(gb_ren), '0);
      check("rst_raddr", LW'(gb_raddr), '0);
      check("rst_valid", LW'(m_valid), '0);
      check("rst_data", m_data, '0);
      check("rst_last", LW'(m_last), '0);
      check("rst_busy", LW'(busy), '0);
      check("rst_done", LW'(done), '0);
      xfer = 0; nrd = 0; npop = 0; done_cyc = -1; last_addr = '0;
    end else begin
      e_busy  = xfer && cyc >= s_cyc + 1 && (done_cyc < 0 || cyc < done_cyc);
      e_done  = xfer && cyc == done_cyc;
      e_ren   = xfer && cyc >= s_cyc + 1 && nrd < mn && (nrd - npop) < DEPTH;
      e_valid = xfer && npop < nrd && avail[npop] <= cyc;
      e_addr  = e_ren ? AW'(mbase + AW'(nrd)) : last_addr;
      e_data  = e_valid ? line_of(AW'(mbase + AW'(npop))) : '0;
      e_last  = e_valid && npop == mn - 1;
      check("gb_ren", LW'(gb_ren), LW'(e_ren));
      check("gb_raddr", LW'(gb_raddr), LW'(e_addr));
      check("m_valid", LW'(m_valid), LW'(e_valid));
      check("m_data", m_data, e_data);
      check("m_last", LW'(m_last), LW'(e_last));
      check("busy", LW'(busy), LW'(e_busy));
      check("done", LW'(done), LW'(e_done));
      if (e_ren) begin
        avail[nrd] = cyc + 2;
        nrd++;
        last_addr = e_addr;
        addr_log.push_back(gb_raddr);
      end
      if (e_valid && m_ready) begin
        npop++;
        if (e_last) last_cnt++;
        if (npop == mn) done_cyc = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (e_done) xfer = 0;
      else if (!xfer && start) begin
        xfer = 1; s_cyc = cyc; mn = int'(n_lines); mbase = base_addr;
        nrd = 0; npop = 0;
        done_cyc = (mn == 0) ? cyc + 2 : -1;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n, output int sc);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; n_lines = n;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    check(nm, LW'(done_cnt - d0), LW'(1));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int sc, l0, dc0;
    rstn = 1'b0; start = 1'b0; base_addr = '0; n_lines = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // T1: consecutive addresses, one m_last, one done
    rdy_mode = 0; addr_log.delete(); l0 = last_cnt;
    pulse_start(17'h100, 17'd8, sc);
    wait_done("t1_done", 200);
    check("t1_nreads", LW'(addr_log.size()), LW'(8));
    check("t1_first", LW'(addr_log[0]), LW'(17'h100));
    check("t1_final", LW'(addr_log[7]), LW'(17'h107));
    check("t1_lastcnt", LW'(last_cnt - l0), LW'(1));

    // T2: host stalls 10 cycles after first m_valid
    rdy_mode = 2; addr_log.delete();
    pulse_start(17'h2A0, 17'd6, sc);
    for (int i = 0; i < 20 && !m_valid; i++) @(posedge clk);
    check("t2_valid_seen", LW'(m_valid), LW'(1));
    check("t2_latency", LW'(cyc - sc), LW'(3));
    repeat (10) @(posedge clk);
    check("t2_outstanding", LW'(addr_log.size()), LW'(4));
    rdy_mode = 0;
    wait_done("t2_done", 200);

    // T3: random backpressure, 32 lines
    rdy_mode = 1; l0 = last_cnt;
    pulse_start(17'h0C00, 17'd32, sc);
    wait_done("t3_done", 600);
    check("t3_lastcnt", LW'(last_cnt - l0), LW'(1));

    // T4: address wrap
    rdy_mode = 0; addr_log.delete();
    pulse_start(17'h1FFFE, 17'd4, sc);
    wait_done("t4_done", 200);
    check("t4_a1", LW'(addr_log[1]), LW'(17'h1FFFF));
    check("t4_a2", LW'(addr_log[2]), LW'(17'h00000));
    check("t4_a3", LW'(addr_log[3]), LW'(17'h00001));

    // T5: empty transfer, then start pulsed mid-transfer
    addr_log.delete();
    pulse_start(17'h40, 17'd0, sc);
    wait_done("t5_done", 20);
    check("t5_done_at", LW'(last_done_cyc - sc), LW'(2));
    check("t5_noreads", LW'(addr_log.size()), LW'(0));
    rdy_mode = 1; addr_log.delete();
    pulse_start(17'h300, 17'd8, sc);
    repeat (3) @(posedge clk);
    pulse_start(17'h500, 17'd3, sc);
    wait_done("t5_mid_done", 300);
    check("t5_mid_nreads", LW'(addr_log.size()), LW'(8));
    check("t5_mid_final", LW'(addr_log[7]), LW'(17'h307));

    // T6: reset after 3 beats, then a fresh transfer
    rdy_mode = 0; dc0 = done_cnt;
    pulse_start(17'h800, 17'd12, sc);
    for (int i = 0; i < 50 && npop < 3; i++) @(posedge clk);
    check("t6_beats", LW'(npop >= 3), LW'(1));
    #1 rstn = 1'b0;
    #1;
    check("t6_valid0", LW'(m_valid), LW'(0));
    check("t6_busy0", LW'(busy), LW'(0));
    check("t6_ren0", LW'(gb_ren), LW'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    check("t6_nodone", LW'(done_cnt - dc0), LW'(0));
    pulse_start(17'h900, 17'd5, sc);
    wait_done("t6_fresh_done", 200);

    // Random transfers
    for (int t = 0; t < 8; t++) begin
      rdy_mode = int'($urandom_range(0, 1));
      l0 = last_cnt;
      pulse_start(AW'($urandom), AW'($urandom_range(1, 24)), sc);
      wait_done("rand_done", 500);
      check("rand_lastcnt", LW'(last_cnt - l0), LW'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
